// File: rtl/alu_seq_core_if.sv
// alu_seq_core_if: command/result handshake bundle for alu_seq_core; ALU_SEQ_FLAGS_EN adds zero/neg
interface alu_seq_core_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [3:0]         op;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic               overflow;
    logic               err;
`ifdef ALU_SEQ_FLAGS_EN
    logic               zero;
    logic               neg;
`endif

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, overflow, err
`ifdef ALU_SEQ_FLAGS_EN
        , zero, neg
`endif
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, overflow, err
`ifdef ALU_SEQ_FLAGS_EN
        , zero, neg
`endif
    );
endinterface

// File: rtl/alu_seq_core.sv
// alu_seq_core: multi-cycle 16-op ALU with iterative mul/div; ALU_SEQ_FLAGS_EN adds zero/neg flags
module alu_seq_core #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           reset,
    alu_seq_core_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [3:0]         r_op;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ovf;
    logic               r_err;
`ifdef ALU_SEQ_FLAGS_EN
    logic               r_zero;
    logic               r_neg;
`endif

    logic               w_accept;
    logic               w_multi;
    logic               w_fin;
    logic               w_iter;
    logic               w_div0;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_dsh;
    logic [WIDTH:0]     w_dsub;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_sc_res;
    logic               w_sc_ovf;
    logic [2*WIDTH-1:0] w_fin_res;

    assign w_accept = bus.in_valid && r_state == IDLE;
    assign w_div0   = r_op == 4'd3 && r_b == '0;
    assign w_multi  = r_op == 4'd2 || (r_op == 4'd3 && !w_div0);
    assign w_fin    = r_state == EXEC && (!w_multi || r_cnt == CW'(WIDTH));
    assign w_iter   = r_state == EXEC && w_multi && r_cnt != CW'(WIDTH);
    assign w_sh     = r_b[SHW-1:0];
    assign w_add    = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub    = {1'b0, r_a} - {1'b0, r_b};

    // One shift-add or restoring-divide step on the {hi, lo} accumulator
    always_comb begin
        w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
        w_dsh     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_dsub    = w_dsh - {1'b0, r_b};
        w_acc_nxt = r_op == 4'd2
                  ? (r_acc[0] ? {w_msum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]})
                  : (!w_dsub[WIDTH] ? {w_dsub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                                    : {w_dsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0});
    end

    // Single-cycle operation results, including the divide-by-zero pattern
    always_comb begin
        w_sc_res = '0;
        w_sc_ovf = 1'b0;
        case (r_op)
            4'd0: begin
                w_sc_res = {{(WIDTH-1){1'b0}}, w_add};
                w_sc_ovf = r_a[WIDTH-1] == r_b[WIDTH-1] && w_add[WIDTH-1] != r_a[WIDTH-1];
            end
            4'd1: begin
                w_sc_res = {{(WIDTH-1){1'b0}}, w_sub};
                w_sc_ovf = r_a[WIDTH-1] != r_b[WIDTH-1] && w_sub[WIDTH-1] != r_a[WIDTH-1];
            end
            4'd3:  w_sc_res = {r_a, {WIDTH{1'b1}}};
            4'd4:  w_sc_res = {{WIDTH{1'b0}}, r_a << w_sh};
            4'd5:  w_sc_res = {{WIDTH{1'b0}}, r_a >> w_sh};
            4'd6:  w_sc_res = {{WIDTH{1'b0}}, (r_a << w_sh) | (r_a >> (WIDTH - int'(w_sh)))};
            4'd7:  w_sc_res = {{WIDTH{1'b0}}, (r_a >> w_sh) | (r_a << (WIDTH - int'(w_sh)))};
            4'd8:  w_sc_res = {{WIDTH{1'b0}}, r_a & r_b};
            4'd9:  w_sc_res = {{WIDTH{1'b0}}, r_a | r_b};
            4'd10: w_sc_res = {{WIDTH{1'b0}}, r_a ^ r_b};
            4'd11: w_sc_res = {{WIDTH{1'b0}}, ~(r_a | r_b)};
            4'd12: w_sc_res = {{WIDTH{1'b0}}, ~(r_a & r_b)};
            4'd13: w_sc_res = {{WIDTH{1'b0}}, ~(r_a ^ r_b)};
            4'd14: w_sc_res = {{(2*WIDTH-1){1'b0}}, r_a > r_b};
            4'd15: w_sc_res = {{(2*WIDTH-1){1'b0}}, r_a == r_b};
            default: w_sc_res = '0;
        endcase
        w_fin_res = w_multi ? r_acc : w_sc_res;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: accept in IDLE, finish EXEC, wait for consumer in DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = bus.in_valid ? EXEC : IDLE;
            EXEC:    w_state_nxt = w_fin ? DONE : EXEC;
            DONE:    w_state_nxt = bus.out_ready ? IDLE : DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_op  <= bus.op;
            r_cnt <= '0;
            r_acc <= {{WIDTH{1'b0}}, bus.a};
        end else begin
            if (w_iter) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_fin) begin
                r_result <= w_fin_res;
                r_ovf    <= w_sc_ovf;
                r_err    <= w_div0;
`ifdef ALU_SEQ_FLAGS_EN
                r_zero   <= w_fin_res == '0;
                r_neg    <= (r_op == 4'd0 || r_op == 4'd1) && w_fin_res[WIDTH-1];
`endif
            end
        end
    end

    assign bus.in_ready  = r_state == IDLE;
    assign bus.out_valid = r_state == DONE;
    assign bus.result    = r_result;
    assign bus.overflow  = r_ovf;
    assign bus.err       = r_err;
`ifdef ALU_SEQ_FLAGS_EN
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;
`endif
endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed-vector bench for alu_seq_core at WIDTH=8
module tb_alu_seq_core;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    alu_seq_core_if #(.WIDTH(8)) bus ();

    alu_seq_core #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                       input logic [15:0] er, input logic eo, input logic ee, input int el);
        int lat;
        @(negedge clk);
        bus.op       = o;
        bus.a        = xa;
        bus.b        = xb;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = ~xa;
        bus.b        = ~xb;
        bus.op       = ~o;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".lat"}, lat, el);
        check({tag, ".res"}, bus.result, er);
        check({tag, ".ovf"}, bus.overflow, eo);
        check({tag, ".err"}, bus.err, ee);
        check({tag, ".rdy"}, bus.in_ready, 0);
        @(posedge clk);
        #1;
        check({tag, ".idle"}, {bus.in_ready, bus.out_valid}, 2'b10);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.state", {bus.in_ready, bus.out_valid, bus.overflow, bus.err}, 4'b1000);
        check("rst.res", bus.result, 0);
        @(negedge clk);
        reset = 1'b0;

        run("add7f",  4'd0,  8'h7F, 8'h01, 16'h0080, 1'b1, 1'b0, 2);
        run("addff",  4'd0,  8'hFF, 8'h01, 16'h0100, 1'b0, 1'b0, 2);
        run("sub35",  4'd1,  8'h03, 8'h05, 16'h01FE, 1'b0, 1'b0, 2);
        run("sub80",  4'd1,  8'h80, 8'h01, 16'h007F, 1'b1, 1'b0, 2);
        run("mulff",  4'd2,  8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 10);
        run("mul0d",  4'd2,  8'h0D, 8'h0B, 16'h008F, 1'b0, 1'b0, 10);
        run("div200", 4'd3,  8'hC8, 8'h07, 16'h041C, 1'b0, 1'b0, 10);
        run("div100", 4'd3,  8'h64, 8'h0A, 16'h000A, 1'b0, 1'b0, 10);
        run("div0",   4'd3,  8'h2A, 8'h00, 16'h2AFF, 1'b0, 1'b1, 2);
        run("lsl",    4'd4,  8'h0F, 8'h04, 16'h00F0, 1'b0, 1'b0, 2);
        run("lsr",    4'd5,  8'hF0, 8'h04, 16'h000F, 1'b0, 1'b0, 2);
        run("rol",    4'd6,  8'h81, 8'h01, 16'h0003, 1'b0, 1'b0, 2);
        run("ror",    4'd7,  8'h01, 8'h09, 16'h0080, 1'b0, 1'b0, 2);
        run("and",    4'd8,  8'hCC, 8'hAA, 16'h0088, 1'b0, 1'b0, 2);
        run("or",     4'd9,  8'hCC, 8'hAA, 16'h00EE, 1'b0, 1'b0, 2);
        run("xor",    4'd10, 8'hCC, 8'hAA, 16'h0066, 1'b0, 1'b0, 2);
        run("nor",    4'd11, 8'hCC, 8'hAA, 16'h0011, 1'b0, 1'b0, 2);
        run("nand",   4'd12, 8'hCC, 8'hAA, 16'h0077, 1'b0, 1'b0, 2);
        run("xnor",   4'd13, 8'hCC, 8'hAA, 16'h0099, 1'b0, 1'b0, 2);
        run("gt",     4'd14, 8'h05, 8'h03, 16'h0001, 1'b0, 1'b0, 2);
        run("gtn",    4'd14, 8'h03, 8'h05, 16'h0000, 1'b0, 1'b0, 2);
        run("eqn",    4'd15, 8'h05, 8'h03, 16'h0000, 1'b0, 1'b0, 2);
        run("eq",     4'd15, 8'h05, 8'h05, 16'h0001, 1'b0, 1'b0, 2);

        // Backpressure: hold DONE while a competing command is offered
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.op = 4'd10; bus.a = 8'hF0; bus.b = 8'h3C; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.op = 4'd0; bus.a = 8'h11; bus.b = 8'h22;
        repeat (2) @(posedge clk);
        #1;
        check("bp.valid", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp.hold", {bus.out_valid, bus.in_ready, bus.result}, {2'b10, 16'h00CC});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp.rel", {bus.in_ready, bus.out_valid}, 2'b10);
        repeat (3) @(posedge clk);
        #1;
        check("bp.noacc", {bus.in_ready, bus.out_valid}, 2'b10);

        // Reset in the middle of a multiply
        @(negedge clk);
        bus.op = 4'd2; bus.a = 8'hFF; bus.b = 8'hFF; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mrst.state", {bus.in_ready, bus.out_valid, bus.overflow, bus.err}, 4'b1000);
        check("mrst.res", bus.result, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mrst.after", {bus.in_ready, bus.out_valid}, 2'b10);
        run("add23", 4'd0, 8'h02, 8'h03, 16'h0005, 1'b0, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
